prince_sbox_layer_sched: RTL

- Nibble-group scheduler directly upstream and downstream of the 4-S-box masked inverse-S-box group (16-bit, 3-share, registered pipeline).
- Latches a full 64-bit, 3-share PRINCE state and feeds it to the group as four 16-bit chunks on consecutive cycles.
- Collects the returned chunks after the group's pipeline latency and reassembles the 64-bit, 3-share result.
- Requests fresh randomness while the group pipeline is active. Shares are never combined inside this block.

---
 rtl/prince_mask_pkg.sv | 11 +
 rtl/prince_tag_pipe.sv | 35 +++
 rtl/prince_sbox_layer_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/prince_mask_pkg.sv
// Shared constants and types for the 3-share masked PRINCE datapath.
package prince_mask_pkg;
   localparam int NSHARES         = 3;
   localparam int CHUNK_W         = 16;
   localparam int NCHUNK          = 4;
   localparam int STATE_W         = 64;
   localparam int SBOX_GRP_RAND_W = 168;
   localparam int IDX_W           = $clog2(NCHUNK);

   typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN, ST_DONE} sched_state_e;
endpackage

// File: rtl/prince_tag_pipe.sv
// Shift register of {valid, chunk index} tracking chunks inside the S-box group pipeline.
module prince_tag_pipe
   import prince_mask_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_vld,
   input  logic [IDX_W-1:0] i_idx,
   output logic             o_vld,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any_vld
);
   logic [DEPTH-1:0]            r_vld;
   logic [DEPTH-1:0][IDX_W-1:0] r_idx;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld <= '0;
         r_idx <= '0;
      end else begin
         r_vld[0] <= i_vld;
         r_idx[0] <= i_idx;
         for (int i = 1; i < DEPTH; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_idx[i] <= r_idx[i-1];
         end
      end
   end

   assign o_vld     = r_vld[DEPTH-1];
   assign o_idx     = r_idx[DEPTH-1];
   assign o_any_vld = |r_vld;
endmodule

// File: rtl/prince_sbox_layer_sched.sv
// Feeds a latched 3-share 64-bit state to the 16-bit S-box group chunk by chunk and
// reassembles the returned chunks; every share keeps its own registers and muxes.
module prince_sbox_layer_sched
   import prince_mask_pkg::*;
#(
   parameter int SBOX_LAT = 4,
   parameter int NCHUNK   = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [STATE_W-1:0] i_state_in1,
   input  logic [STATE_W-1:0] i_state_in2,
   input  logic [STATE_W-1:0] i_state_in3,
   output logic               o_busy,
   output logic               o_done,
   output logic [STATE_W-1:0] o_state_out1,
   output logic [STATE_W-1:0] o_state_out2,
   output logic [STATE_W-1:0] o_state_out3,
   output logic [CHUNK_W-1:0] o_sb_in1,
   output logic [CHUNK_W-1:0] o_sb_in2,
   output logic [CHUNK_W-1:0] o_sb_in3,
   input  logic [CHUNK_W-1:0] i_sb_out1,
   input  logic [CHUNK_W-1:0] i_sb_out2,
   input  logic [CHUNK_W-1:0] i_sb_out3,
   output logic               o_rnd_en
);
   localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NCHUNK - 1);

   sched_state_e r_state, w_state_nxt;
   logic [IDX_W-1:0] r_k, w_k_nxt;
   logic             w_accept, w_feed_next;
   logic             w_tag_vld, w_any_vld;
   logic [IDX_W-1:0] w_tag_idx;

   logic [NSHARES-1:0][STATE_W-1:0] w_st_in, w_out;
   logic [NSHARES-1:0][CHUNK_W-1:0] w_sb_out, w_sb_in;

   assign w_st_in     = {i_state_in3, i_state_in2, i_state_in1};
   assign w_sb_out    = {i_sb_out3, i_sb_out2, i_sb_out1};
   assign w_accept    = (r_state == ST_IDLE) && i_start;
   assign w_feed_next = (r_state == ST_FEED) && (r_k != K_LAST);
   assign w_k_nxt     = r_k + 1'b1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:  if (i_start) w_state_nxt = ST_FEED;
         ST_FEED:  if (r_k == K_LAST) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (w_tag_vld && (w_tag_idx == K_LAST)) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // rnd_en also covers chunks still in flight after FEED ends
   always_comb begin
      o_busy   = 1'b0;
      o_done   = 1'b0;
      o_rnd_en = w_any_vld;
      unique case (r_state)
         ST_IDLE:  ;
         ST_FEED:  begin o_busy = 1'b1; o_rnd_en = 1'b1; end
         ST_DRAIN: o_busy = 1'b1;
         ST_DONE:  begin o_busy = 1'b1; o_done = 1'b1; end
         default:  ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                 r_k <= '0;
      else if (w_accept)            r_k <= '0;
      else if (r_state == ST_FEED)  r_k <= w_k_nxt;
   end

   prince_tag_pipe #(.DEPTH(SBOX_LAT)) u_tag_pipe (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_vld     (r_state == ST_FEED),
      .i_idx     (r_k),
      .o_vld     (w_tag_vld),
      .o_idx     (w_tag_idx),
      .o_any_vld (w_any_vld)
   );

   // sb_in is registered and forced to zero outside FEED so stale chunks never glitch together
   for (genvar s = 0; s < NSHARES; s++) begin : g_sh
      logic [STATE_W-1:0] r_sh, r_out;
      logic [CHUNK_W-1:0] r_sb_in;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_sh    <= '0;
            r_out   <= '0;
            r_sb_in <= '0;
         end else begin
            if (w_accept) begin
               r_sh    <= w_st_in[s];
               r_sb_in <= w_st_in[s][CHUNK_W-1:0];
            end else if (w_feed_next) begin
               r_sb_in <= r_sh[w_k_nxt*CHUNK_W +: CHUNK_W];
            end else begin
               r_sb_in <= '0;
            end
            if (w_tag_vld) r_out[w_tag_idx*CHUNK_W +: CHUNK_W] <= w_sb_out[s];
         end
      end

      assign w_sb_in[s] = r_sb_in;
      assign w_out[s]   = r_out;
   end

   assign o_sb_in1     = w_sb_in[0];
   assign o_sb_in2     = w_sb_in[1];
   assign o_sb_in3     = w_sb_in[2];
   assign o_state_out1 = w_out[0];
   assign o_state_out2 = w_out[1];
   assign o_state_out3 = w_out[2];
endmodule
